// File: rtl/grid_arb.sv
// Grid RAM arbiter: full-grid clear sequencer, display reads, and paint writes on one single-port RAM.
// Optional starvation guard for writes is enabled by defining GRID_ARB_STARVE_GUARD_EN.
module grid_arb #(
  parameter int HSIZE  = 96,
  parameter int VSIZE  = 54,
  parameter int STARVE = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        clr_start,
  input  logic        disp_req,
  input  logic [8:0]  disp_row,
  input  logic [8:0]  disp_col,
  output logic        disp_data,
  output logic        disp_valid,
  input  logic        wr_req,
  input  logic [8:0]  wr_row,
  input  logic [8:0]  wr_col,
  output logic        wr_ack,
  output logic        busy,
  output logic [12:0] mem_addr,
  output logic        mem_we,
  output logic        mem_wdata,
  input  logic        mem_rdata
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [12:0] LAST_ADDR = 13'(HSIZE * VSIZE - 1);
  localparam logic [9:0]  HLIM      = 10'(HSIZE);
  localparam logic [9:0]  VLIM      = 10'(VSIZE);

  function automatic logic [12:0] cell_addr(input logic [8:0] row, input logic [8:0] col);
    return 13'(row) * 13'(HSIZE) + 13'(col);
  endfunction

  state_t      state_q, state_d;
  logic [12:0] clr_cnt_q, clr_cnt_d;
  logic        disp_valid_q, disp_valid_d;
  logic        disp_oob_q, disp_oob_d;

  logic [12:0] addr_c;
  logic        we_c, wdata_c, ack_c, wr_grant;
  logic        starve;
  logic        wr_in_range, disp_in_range;

  assign wr_in_range   = ({1'b0, wr_row} < VLIM) && ({1'b0, wr_col} < HLIM);
  assign disp_in_range = ({1'b0, disp_row} < VLIM) && ({1'b0, disp_col} < HLIM);

`ifdef GRID_ARB_STARVE_GUARD_EN
  localparam int unsigned CW = $clog2(STARVE + 1);
  logic [CW-1:0] wait_q, wait_d;

  assign starve = (wait_q == CW'(STARVE));

  // Counts only cycles where the write lost to a display grant.
  always_comb begin
    wait_d = wait_q;
    if (wr_grant) begin
      wait_d = '0;
    end else if (state_q == IDLE && !clr_start && wr_req && !starve) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) wait_q <= '0;
    else        wait_q <= wait_d;
  end
`else
  assign starve = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    disp_valid_d = 1'b0;
    disp_oob_d   = 1'b0;
    addr_c       = '0;
    we_c         = 1'b0;
    wdata_c      = 1'b0;
    ack_c        = 1'b0;
    wr_grant     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else if (disp_req && !(wr_req && starve)) begin
          disp_valid_d = 1'b1;
          if (disp_in_range) addr_c = cell_addr(disp_row, disp_col);
          else               disp_oob_d = 1'b1;
        end else if (wr_req) begin
          wr_grant = 1'b1;
          ack_c    = 1'b1;
          if (wr_in_range) begin
            addr_c  = cell_addr(wr_row, wr_col);
            we_c    = 1'b1;
            wdata_c = 1'b1;
          end
        end
      end
      CLEAR: begin
        we_c   = 1'b1;
        addr_c = clr_cnt_q;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q      <= IDLE;
      clr_cnt_q    <= '0;
      disp_valid_q <= 1'b0;
      disp_oob_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      disp_valid_q <= disp_valid_d;
      disp_oob_q   <= disp_oob_d;
    end
  end

  // RAM read data arrives in the cycle after the grant, so disp_data is qualified by the registered grant.
  assign busy       = RESET && (state_q == CLEAR);
  assign disp_valid = RESET && disp_valid_q;
  assign disp_data  = RESET && disp_valid_q && !disp_oob_q && mem_rdata;
  assign wr_ack     = RESET && ack_c;
  assign mem_we     = RESET && we_c;
  assign mem_wdata  = RESET && wdata_c;
  assign mem_addr   = RESET ? addr_c : '0;

endmodule

// File: doc/grid_arb.md
GRID_ARB -- requirements
Module: grid_arb

Interface
REQ-001 SHALL have parameter HSIZE, default 96, meaning grid columns.
REQ-002 SHALL have parameter VSIZE, default 54, meaning grid rows.
REQ-003 SHALL have parameter STARVE, default 4, meaning the wait-cycle limit before a write overrides display.
REQ-004 SHALL have port CLK  in  1  single clock, rising edge.
REQ-005 SHALL have port RESET  in  1  reset, synchronous and active-low.
REQ-006 SHALL have port clr_start  in  1  one-cycle pulse requesting a full-grid clear.
REQ-007 SHALL have port disp_req  in  1  display read request, one cell per cycle.
REQ-008 SHALL have ports disp_row / disp_col  in  9 / 9  display cell coordinates.
REQ-009 SHALL have ports disp_data / disp_valid  out  1 / 1  read cell value / qualifier.
REQ-010 SHALL have port wr_req  in  1  paint request, held until wr_ack.
REQ-011 SHALL have ports wr_row / wr_col  in  9 / 9  paint coordinates.
REQ-012 SHALL have port wr_ack  out  1  one-cycle paint completion.
REQ-013 SHALL have port busy  out  1  clear sequence in progress.
REQ-014 SHALL have ports mem_addr / mem_we / mem_wdata  out  13 / 1 / 1  single-port grid RAM control.
REQ-015 SHALL have port mem_rdata  in  1  RAM read data, valid one cycle after the address.

Function
REQ-016 SHALL form mem_addr as row*HSIZE+col, truncated to 13 bits.
REQ-017 SHALL implement FSM states IDLE, CLEAR, with arbitration performed each IDLE cycle.
REQ-018 SHALL transition IDLE->CLEAR on clr_start, with a clear address counter from 0 and busy=1.
REQ-019 SHALL, in CLEAR, drive mem_we=1, mem_wdata=0 and addr=counter, incrementing by one per cycle.
REQ-020 SHALL make the CLEAR->IDLE transition after writing address HSIZE*VSIZE-1, with busy low on the next cycle.
REQ-021 SHALL ignore clr_start while already in CLEAR, with no counter restart.
REQ-022 SHALL, while in CLEAR, grant neither requester: disp_valid=0 and wr_ack=0.
REQ-023 SHALL, in IDLE, use fixed priority: display over write.
REQ-024 SHALL, on a display grant in cycle N, raise disp_valid in N+1 with disp_data=mem_rdata, registered.
REQ-025 SHALL perform a write grant as mem_we=1, mem_wdata=1 at the requested address, with wr_ack=1 in the same cycle.
REQ-026 SHALL drop a write with wr_row>=VSIZE or wr_col>=HSIZE: no mem_we, and wr_ack is still pulsed.
REQ-027 SHALL drop a display request with out-of-range coordinates: no RAM access, disp_valid=1, disp_data=0 in N+1.
REQ-028 SHALL, on simultaneous clr_start and wr_req, let clear win; the write stays pending and is served after CLEAR.
REQ-029 SHALL clear the wait counter on each write grant and saturate it at STARVE.
REQ-030 SHALL hold mem_we=0 whenever no write or clear is granted.

Reset
REQ-031 SHALL, when RESET=0 at a CLK edge, enter state IDLE with the counters at 0.
REQ-032 SHALL, under reset, drive busy=0, disp_valid=0, disp_data=0, wr_ack=0, mem_we=0, mem_wdata=0 and mem_addr=0.
REQ-033 SHALL abort a CLEAR sequence on reset mid-sequence without resuming, leaving the RAM partially cleared.

Configuration
REQ-034 SHALL provide macro GRID_ARB_STARVE_GUARD_EN.
REQ-035 SHALL, with the macro defined, count cycles in which wr_req is pending and denied; at STARVE, the write wins over display for one grant.
REQ-036 SHALL, in that case, keep disp_valid=0 for the displaced display cycle.
REQ-037 SHALL, without the macro, apply pure display priority, with no wait counter logic present.

Verification
REQ-038 SHALL cover reset: RESET=0 for 2 cycles -> all outputs 0, state IDLE.
REQ-039 SHALL cover a paint: wr_req at (2,3) with no disp_req -> mem_addr=195, mem_we=1, wr_ack in the same cycle.
REQ-040 SHALL cover a clear: clr_start pulse -> busy high for exactly 5184 cycles, last mem_addr=5183, then IDLE.
REQ-041 SHALL cover a collision: disp_req and wr_req held continuously with the guard macro defined -> wr_ack on the 5th cycle; without the macro -> no wr_ack.
REQ-042 SHALL cover out-of-range: wr_row=54 -> wr_ack=1, mem_we=0; disp_col=96 -> disp_valid=1, disp_data=0.
REQ-043 SHALL cover reset mid-clear: RESET=0 at count 100 -> busy=0 on the next cycle, and a subsequent clr_start restarts from 0.
